// File: rtl/intr_pkg.sv
// Shared constants for the interrupt controller: FSM state encoding, cause codes,
// irq bit positions and mtvec mode values.
package intr_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StWaitPc = 2'd1;
  localparam state_t StTrap   = 2'd2;
  localparam state_t StHold   = 2'd3;

  localparam int unsigned IrqSw    = 0;
  localparam int unsigned IrqTimer = 1;
  localparam int unsigned IrqExt   = 2;

  localparam logic [3:0] CauseSw    = 4'd3;
  localparam logic [3:0] CauseTimer = 4'd7;
  localparam logic [3:0] CauseExt   = 4'd11;

  localparam logic [1:0] MtvecDirect   = 2'b00;
  localparam logic [1:0] MtvecVectored = 2'b01;

  // External beats software beats timer, which is not the numeric cause order.
  function automatic logic [3:0] win_code(input logic [2:0] pend);
    if (pend[IrqExt]) begin
      return CauseExt;
    end else if (pend[IrqSw]) begin
      return CauseSw;
    end else begin
      return CauseTimer;
    end
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Pipeline/CSR-side signal bundle of the interrupt controller. The controller
// uses the slave modport; the pipeline and CSR file use master.
interface intr_ctrl_if;
  logic [2:0]  irq_i;
  logic [2:0]  mie_i;
  logic        mstatus_mie_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        is_mret_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic        csr_trap_wr_o;
  logic [31:0] mepc_wdata_o;
  logic [31:0] mcause_wdata_o;
  logic        csr_mret_o;
  logic [2:0]  mip_o;

  modport master (
    output irq_i, mie_i, mstatus_mie_i, mtvec_i, mepc_i, pc_i, pc_valid_i, is_mret_i,
    input  redirect_o, redirect_pc_o, flush_o, csr_trap_wr_o, mepc_wdata_o,
    input  mcause_wdata_o, csr_mret_o, mip_o
  );

  modport slave (
    input  irq_i, mie_i, mstatus_mie_i, mtvec_i, mepc_i, pc_i, pc_valid_i, is_mret_i,
    output redirect_o, redirect_pc_o, flush_o, csr_trap_wr_o, mepc_wdata_o,
    output mcause_wdata_o, csr_mret_o, mip_o
  );
endinterface

// File: rtl/intr_sync.sv
// Per-bit two-flop synchronizer for asynchronous interrupt request lines.
module intr_sync #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller: takes traps at the MW stage and handles MRET.
// Define INTR_SYNC_EN to pass irq_i through a 2-flop synchronizer before mip_o.
module intr_ctrl
  import intr_pkg::*;
(
  input logic         clk,
  input logic         reset,
  intr_ctrl_if.slave  bus
);

  logic [2:0] mip;

`ifdef INTR_SYNC_EN
  intr_sync #(
    .Width(3)
  ) u_intr_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (bus.irq_i),
    .q_o    (mip)
  );
`else
  assign mip = bus.irq_i;
`endif

  logic [2:0] pend;
  logic       take;

  assign pend = mip & bus.mie_i;
  assign take = bus.mstatus_mie_i & (|pend);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  code_q, code_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (take) state_d = StWaitPc;
      end
      StWaitPc: begin
        // Losing the request wins over a valid PC: there is no cause left to record.
        if (!take) begin
          state_d = StIdle;
        end else if (bus.pc_valid_i) begin
          state_d = StTrap;
          pc_d    = bus.pc_i;
          code_d  = win_code(pend);
        end
      end
      StTrap:  state_d = StHold;
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic [31:0] base;
  logic [31:0] target;

  assign base   = {bus.mtvec_i[31:2], 2'b00};
  assign target = (bus.mtvec_i[1:0] == MtvecVectored) ? base + {26'b0, code_q, 2'b00} : base;

  logic        redirect, flush, trap_wr, mret;
  logic [31:0] redirect_pc, mepc_wdata, mcause_wdata;

  // Outputs are gated by reset so nothing escapes while the block is held in reset.
  always_comb begin
    redirect     = 1'b0;
    flush        = 1'b0;
    trap_wr      = 1'b0;
    mret         = 1'b0;
    redirect_pc  = '0;
    mepc_wdata   = '0;
    mcause_wdata = '0;
    if (reset) begin
      if (state_q == StTrap) begin
        redirect     = 1'b1;
        flush        = 1'b1;
        trap_wr      = 1'b1;
        redirect_pc  = target;
        mepc_wdata   = pc_q;
        mcause_wdata = {1'b1, 27'b0, code_q};
      end else if (state_q == StIdle && !take && bus.pc_valid_i && bus.is_mret_i) begin
        redirect    = 1'b1;
        flush       = 1'b1;
        mret        = 1'b1;
        redirect_pc = bus.mepc_i;
      end
    end
  end

  assign bus.redirect_o     = redirect;
  assign bus.redirect_pc_o  = redirect_pc;
  assign bus.flush_o        = flush;
  assign bus.csr_trap_wr_o  = trap_wr;
  assign bus.mepc_wdata_o   = mepc_wdata;
  assign bus.mcause_wdata_o = mcause_wdata;
  assign bus.csr_mret_o     = mret;
  assign bus.mip_o          = reset ? mip : 3'b000;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the trap/MRET rules.
module tb_intr_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  intr_ctrl_if bus ();

  intr_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: a trap request is armed, then fires on the first valid PC,
  // then a one-cycle cool-down follows.
  logic        m_armed, m_fire, m_cool;
  logic [31:0] m_pc;
  int          m_code;
  logic [2:0]  m_hist [2];

  function automatic int ref_code(input logic [2:0] p);
    int order [3] = '{2, 0, 1};
    int codes [3] = '{3, 7, 11};
    foreach (order[i]) if (p[order[i]]) return codes[order[i]];
    return 0;
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] mtvec, input int code);
    logic [31:0] b = mtvec & 32'hFFFF_FFFC;
    return (mtvec % 4 == 1) ? b + 32'(code * 4) : b;
  endfunction

  function automatic logic [2:0] ref_mip();
    if (!reset) return 3'b000;
`ifdef INTR_SYNC_EN
    return m_hist[1];
`else
    return bus.irq_i;
`endif
  endfunction

  logic        seen_redirect, seen_flush, seen_trap_wr, seen_mret;
  logic [31:0] seen_rpc, seen_mepc, seen_mcause;
  logic [2:0]  seen_mip;

  task automatic step();
    logic [2:0]  mip_e;
    logic        take_e;
    logic        e_red, e_fl, e_tw, e_mr;
    logic [31:0] e_rpc, e_mepc, e_mc;
    #1;
    mip_e  = ref_mip();
    take_e = bus.mstatus_mie_i && ((mip_e & bus.mie_i) != 0);
    {e_red, e_fl, e_tw, e_mr} = 4'b0;
    {e_rpc, e_mepc, e_mc} = '0;
    if (reset) begin
      if (m_fire) begin
        {e_red, e_fl, e_tw} = 3'b111;
        e_rpc  = ref_target(bus.mtvec_i, m_code);
        e_mepc = m_pc;
        e_mc   = 32'h8000_0000 + 32'(m_code);
      end else if (!m_armed && !m_cool && !take_e && bus.pc_valid_i && bus.is_mret_i) begin
        {e_red, e_fl, e_mr} = 3'b111;
        e_rpc = bus.mepc_i;
      end
    end
    check_val("redirect", 32'(bus.redirect_o), 32'(e_red));
    check_val("flush", 32'(bus.flush_o), 32'(e_fl));
    check_val("trap_wr", 32'(bus.csr_trap_wr_o), 32'(e_tw));
    check_val("mret", 32'(bus.csr_mret_o), 32'(e_mr));
    check_val("redirect_pc", bus.redirect_pc_o, e_rpc);
    check_val("mepc_wdata", bus.mepc_wdata_o, e_mepc);
    check_val("mcause", bus.mcause_wdata_o, e_mc);
    check_val("mip", 32'(bus.mip_o), 32'(mip_e));
    seen_redirect = bus.redirect_o;
    seen_flush    = bus.flush_o;
    seen_trap_wr  = bus.csr_trap_wr_o;
    seen_mret     = bus.csr_mret_o;
    seen_rpc      = bus.redirect_pc_o;
    seen_mepc     = bus.mepc_wdata_o;
    seen_mcause   = bus.mcause_wdata_o;
    seen_mip      = bus.mip_o;
    @(posedge clk);
    if (!reset) begin
      {m_armed, m_fire, m_cool} = 3'b000;
      m_pc = '0;
      m_code = 0;
      m_hist[0] = '0;
      m_hist[1] = '0;
    end else begin
      m_hist[1] = m_hist[0];
      m_hist[0] = bus.irq_i;
      if (m_fire) begin
        m_fire = 1'b0;
        m_cool = 1'b1;
      end else if (m_cool) begin
        m_cool = 1'b0;
      end else if (m_armed) begin
        if (!take_e) begin
          m_armed = 1'b0;
        end else if (bus.pc_valid_i) begin
          m_armed = 1'b0;
          m_fire  = 1'b1;
          m_pc    = bus.pc_i;
          m_code  = ref_code(mip_e & bus.mie_i);
        end
      end else if (take_e) begin
        m_armed = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Steps until a redirect is observed; returns the number of steps before it.
  task automatic run_to_redirect(input string tag, input int limit, output int lat);
    logic got = 1'b0;
    lat = -1;
    for (int i = 0; i < limit && !got; i++) begin
      step();
      if (seen_redirect) begin
        got = 1'b1;
        lat = i;
      end
    end
    check_val({tag, "_reached"}, 32'(got), 32'd1);
  endtask

  task automatic quiesce();
    bus.irq_i = 3'b000;
    bus.mstatus_mie_i = 1'b0;
    bus.is_mret_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
  endtask

`ifdef INTR_SYNC_EN
  localparam int ExpLat = 4;
`else
  localparam int ExpLat = 2;
`endif

  int lat;
  int red_cnt;

  initial begin
    reset = 1'b0;
    bus.irq_i = '0;
    bus.mie_i = '0;
    bus.mstatus_mie_i = 1'b0;
    bus.mtvec_i = '0;
    bus.mepc_i = '0;
    bus.pc_i = '0;
    bus.pc_valid_i = 1'b0;
    bus.is_mret_i = 1'b0;
    {m_armed, m_fire, m_cool} = 3'b000;
    m_pc = '0;
    m_code = 0;
    m_hist[0] = '0;
    m_hist[1] = '0;
    @(negedge clk);
    // Outputs stay quiet under reset even with an MRET and a pending irq presented.
    bus.irq_i = 3'b111;
    bus.mie_i = 3'b111;
    bus.pc_valid_i = 1'b1;
    bus.is_mret_i = 1'b1;
    step();
    check_val("rst_redirect", 32'(seen_redirect), 32'd0);
    check_val("rst_mip", 32'(seen_mip), 32'd0);
    bus.irq_i = '0;
    bus.is_mret_i = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Timer trap, direct mode.
    bus.mtvec_i = 32'h0000_0100;
    bus.mstatus_mie_i = 1'b1;
    bus.mie_i = 3'b010;
    bus.irq_i = 3'b010;
    bus.pc_i = 32'h40;
    bus.pc_valid_i = 1'b1;
    run_to_redirect("timer", 12, lat);
    check_val("timer_latency", 32'(lat), 32'(ExpLat));
    check_val("timer_rpc", seen_rpc, 32'h100);
    check_val("timer_mepc", seen_mepc, 32'h40);
    check_val("timer_mcause", seen_mcause, 32'h8000_0007);
    check_val("timer_trap_wr", 32'(seen_trap_wr), 32'd1);
    quiesce();

    // All sources pending, vectored mode: external wins.
    bus.mtvec_i = 32'h0000_0201;
    bus.mstatus_mie_i = 1'b1;
    bus.mie_i = 3'b111;
    bus.irq_i = 3'b111;
    bus.pc_i = 32'h1234;
    run_to_redirect("ext", 12, lat);
    check_val("ext_mcause", seen_mcause, 32'h8000_000B);
    check_val("ext_rpc", seen_rpc, 32'h22C);
    quiesce();

    // Globally disabled: pending shows in mip but never traps.
    bus.mie_i = 3'b111;
    bus.irq_i = 3'b100;
    red_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (seen_redirect) red_cnt++;
    end
    check_val("masked_redirects", 32'(red_cnt), 32'd0);
    check_val("masked_mip", 32'(seen_mip), 32'h4);
    quiesce();

    // MRET with nothing pending.
    bus.mstatus_mie_i = 1'b1;
    bus.mepc_i = 32'h80;
    bus.is_mret_i = 1'b1;
    step();
    check_val("mret_redirect", 32'(seen_redirect), 32'd1);
    check_val("mret_pulse", 32'(seen_mret), 32'd1);
    check_val("mret_flush", 32'(seen_flush), 32'd1);
    check_val("mret_rpc", seen_rpc, 32'h80);
    quiesce();

    // Interrupt beats MRET; the MRET PC is saved as mepc.
    bus.mtvec_i = 32'h0000_0100;
    bus.mstatus_mie_i = 1'b1;
    bus.mie_i = 3'b001;
    bus.irq_i = 3'b001;
    for (int i = 0; i < ExpLat - 2; i++) step();
    bus.is_mret_i = 1'b1;
    bus.pc_i = 32'h300;
    step();
    check_val("beat_no_mret", 32'(seen_mret), 32'd0);
    run_to_redirect("beat", 6, lat);
    check_val("beat_mepc", seen_mepc, 32'h300);
    check_val("beat_mcause", seen_mcause, 32'h8000_0003);
    quiesce();

    // Bubbles in the MW stage while waiting for a PC.
    bus.mstatus_mie_i = 1'b1;
    bus.pc_valid_i = 1'b0;
    bus.irq_i = 3'b010;
    bus.mie_i = 3'b010;
    for (int i = 0; i < ExpLat - 1 + 5; i++) step();
    bus.pc_valid_i = 1'b1;
    bus.pc_i = 32'h64;
    run_to_redirect("bubble", 4, lat);
    check_val("bubble_mepc", seen_mepc, 32'h64);
    quiesce();

    // Reset while waiting for a PC aborts the trap.
    bus.mstatus_mie_i = 1'b1;
    bus.pc_valid_i = 1'b0;
    bus.irq_i = 3'b100;
    bus.mie_i = 3'b100;
    for (int i = 0; i < ExpLat + 1; i++) step();
    reset = 1'b0;
    bus.pc_valid_i = 1'b1;
    red_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (seen_redirect) red_cnt++;
    end
    bus.irq_i = 3'b000;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (seen_redirect) red_cnt++;
    end
    check_val("abort_redirects", 32'(red_cnt), 32'd0);
    quiesce();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) bus.irq_i[$urandom_range(2)] = ~bus.irq_i[$urandom_range(2)];
      if ($urandom_range(15) == 0) bus.mie_i = 3'($urandom);
      if ($urandom_range(15) == 0) bus.mstatus_mie_i = ($urandom_range(3) != 0);
      if ($urandom_range(31) == 0) bus.mtvec_i = $urandom;
      bus.pc_valid_i = ($urandom_range(3) != 0);
      bus.is_mret_i = ($urandom_range(9) == 0);
      bus.pc_i = $urandom & 32'hFFFF_FFFC;
      bus.mepc_i = $urandom & 32'hFFFF_FFFC;
      reset = ($urandom_range(199) != 0);
      step();
    end
    reset = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
